traffic_lights_cmd_seq: RTL and testbench

//  Command initiator for the traffic_lights block. Takes one host request at a

---
 rtl/traffic_lights_cmd_seq.sv | 211 +++++++++++++++++++++
 tb/tb_traffic_lights_cmd_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_cmd_seq.sv
// traffic_lights_cmd_seq: serialises one host request (mode change or full
// timing reconfiguration) into a stream of single-cycle commands for the
// traffic_lights command port. One request is handled at a time; all outputs
// come straight from flops.
module traffic_lights_cmd_seq #(
  parameter int GAP_CYCLES = 1,
  parameter int MIN_TIME   = 1
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [15:0] req_green_i,
  input  logic [15:0] req_red_i,
  input  logic [15:0] req_yellow_i,
  output logic [2:0]  cmd_type_o,
  output logic        cmd_valid_o,
  output logic [15:0] cmd_data_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int DATA_W = 16;
  // Gap counter needs to hold the value GAP_CYCLES; keep at least one bit.
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]     GAP_LAST    = GW'(GAP_CYCLES);
  localparam logic [DATA_W-1:0] MIN_T       = DATA_W'(MIN_TIME);
  localparam logic [1:0]        OP_RECONFIG = 2'd3;
  localparam logic [2:0]        LAST_IDX    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   green_q, green_d;
  logic [DATA_W-1:0]   red_q, red_d;
  logic [DATA_W-1:0]   yellow_q, yellow_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [2:0]          cmd_type_q, cmd_type_d;
  logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                accept;
  logic [2:0]          nxt_idx;

  // Command code for position idx of the sequence belonging to op.
  // Single-command ops map directly onto codes 0..2; RECONFIG walks
  // UNMANAGED, SET_GREEN, SET_RED, SET_YELLOW, ON.
  function automatic logic [2:0] cmd_code(input logic [1:0] op, input logic [2:0] idx);
    logic [2:0] code;
    if (op != OP_RECONFIG) begin
      code = {1'b0, op};
    end else begin
      case (idx)
        3'd0:    code = 3'd2;
        3'd1:    code = 3'd3;
        3'd2:    code = 3'd4;
        3'd3:    code = 3'd5;
        default: code = 3'd0;
      endcase
    end
    return code;
  endfunction

  // Payload for a command code: the latched time for SET_* codes, zero otherwise.
  function automatic logic [DATA_W-1:0] cmd_payload(input logic [2:0] code,
                                                    input logic [DATA_W-1:0] g,
                                                    input logic [DATA_W-1:0] r,
                                                    input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] data;
    case (code)
      3'd3:    data = g;
      3'd4:    data = r;
      3'd5:    data = y;
      default: data = '0;
    endcase
    return data;
  endfunction

  // A reconfiguration is only legal when every phase time meets the minimum.
  function automatic logic times_legal(input logic [DATA_W-1:0] g,
                                       input logic [DATA_W-1:0] r,
                                       input logic [DATA_W-1:0] y);
    return (g >= MIN_T) && (r >= MIN_T) && (y >= MIN_T);
  endfunction

  assign accept  = req_valid_i & ready_q;
  assign nxt_idx = idx_q + 3'd1;

  // Next-state and next-output logic for the issue sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    op_d        = op_q;
    green_d     = green_q;
    red_d       = red_q;
    yellow_d    = yellow_q;
    cmd_valid_d = 1'b0;
    cmd_type_d  = cmd_type_q;
    cmd_data_d  = cmd_data_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Latch the whole request so the host is free to change its inputs.
          op_d     = req_op_i;
          green_d  = req_green_i;
          red_d    = req_red_i;
          yellow_d = req_yellow_i;
          if ((req_op_i == OP_RECONFIG) &&
              !times_legal(req_green_i, req_red_i, req_yellow_i)) begin
            err_d = 1'b1;
          end else begin
            // First command goes out on the cycle right after acceptance;
            // every first command has a zero payload.
            state_d     = S_ISSUE;
            idx_d       = 3'd0;
            cmd_valid_d = 1'b1;
            cmd_type_d  = cmd_code(req_op_i, 3'd0);
            cmd_data_d  = '0;
          end
        end
      end

      S_ISSUE: begin
        if ((op_q != OP_RECONFIG) || (idx_q == LAST_IDX)) begin
          state_d = S_IDLE;
        end else if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          gap_d   = GW'(1);
          idx_d   = nxt_idx;
        end else begin
          idx_d       = nxt_idx;
          cmd_valid_d = 1'b1;
          cmd_type_d  = cmd_code(op_q, nxt_idx);
          cmd_data_d  = cmd_payload(cmd_code(op_q, nxt_idx), green_q, red_q, yellow_q);
        end
      end

      S_GAP: begin
        // idx_q already points at the next command while idling.
        if (gap_q == GAP_LAST) begin
          state_d     = S_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_type_d  = cmd_code(op_q, idx_q);
          cmd_data_d  = cmd_payload(cmd_code(op_q, idx_q), green_q, red_q, yellow_q);
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // Control and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      gap_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 3'd0;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  // Latched request fields; only meaningful once a request has been accepted.
  always_ff @(posedge clk_i) begin
    op_q     <= op_d;
    green_q  <= green_d;
    red_q    <= red_d;
    yellow_q <= yellow_d;
  end

  assign req_ready_o = ready_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_type_o  = cmd_type_q;
  assign cmd_data_o  = cmd_data_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_traffic_lights_cmd_seq.sv
// Directed bench for traffic_lights_cmd_seq: one instance with a one-cycle
// gap and one back-to-back instance, sharing request data and reset.
module tb_traffic_lights_cmd_seq;

  logic        clk = 1'b0;
  logic        srst;
  logic        req_valid, req_valid0;
  logic [1:0]  req_op;
  logic [15:0] req_green, req_red, req_yellow;

  logic        ready, cvalid, busy, err;
  logic [2:0]  ctype;
  logic [15:0] cdata;
  logic        ready0, cvalid0, busy0, err0;
  logic [2:0]  ctype0;
  logic [15:0] cdata0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  traffic_lights_cmd_seq #(.GAP_CYCLES(1), .MIN_TIME(1)) u_dut (
    .clk_i(clk), .srst_i(srst),
    .req_valid_i(req_valid), .req_ready_o(ready), .req_op_i(req_op),
    .req_green_i(req_green), .req_red_i(req_red), .req_yellow_i(req_yellow),
    .cmd_type_o(ctype), .cmd_valid_o(cvalid), .cmd_data_o(cdata),
    .busy_o(busy), .err_o(err)
  );

  traffic_lights_cmd_seq #(.GAP_CYCLES(0), .MIN_TIME(1)) u_dut0 (
    .clk_i(clk), .srst_i(srst),
    .req_valid_i(req_valid0), .req_ready_o(ready0), .req_op_i(req_op),
    .req_green_i(req_green), .req_red_i(req_red), .req_yellow_i(req_yellow),
    .cmd_type_o(ctype0), .cmd_valid_o(cvalid0), .cmd_data_o(cdata0),
    .busy_o(busy0), .err_o(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request to the gapped instance for exactly one edge.
  task automatic send(input logic [1:0] op, input logic [15:0] g,
                      input logic [15:0] r, input logic [15:0] y);
    req_op     = op;
    req_green  = g;
    req_red    = r;
    req_yellow = y;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  exp_t [5];
    logic [15:0] exp_d [5];
    logic [2:0]  t5 [6];

    srst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
    req_op = 2'd0; req_green = '0; req_red = '0; req_yellow = '0;
    step(); step();

    // Reset values
    chk("rst_ready", ready, 0);
    chk("rst_valid", cvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_type", ctype, 0);
    chk("rst_data", cdata, 0);
    chk("rst_ready0", ready0, 0);
    srst = 1'b0;
    step();
    chk("ready_after_rst", ready, 1);
    chk("ready0_after_rst", ready0, 1);

    // Test 1: ON request
    send(2'd0, 16'd0, 16'd0, 16'd0);
    chk("on_valid", cvalid, 1);
    chk("on_type", ctype, 0);
    chk("on_data", cdata, 0);
    chk("on_busy", busy, 1);
    chk("on_ready", ready, 0);
    step();
    chk("on_valid_end", cvalid, 0);
    chk("on_ready_back", ready, 1);
    chk("on_busy_end", busy, 0);

    // UNMANAGED: single pulse code 2, zero payload even if times present
    send(2'd2, 16'd9, 16'd9, 16'd9);
    chk("unm_valid", cvalid, 1);
    chk("unm_type", ctype, 2);
    chk("unm_data", cdata, 0);
    step();
    chk("unm_valid_end", cvalid, 0);

    // Test 2: RECONFIG with one gap cycle; host changes inputs after accept
    exp_t = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    exp_d = '{16'd0, 16'd5, 16'd7, 16'd3, 16'd0};
    send(2'd3, 16'd5, 16'd7, 16'd3);
    req_green = 16'd99; req_red = 16'd98; req_yellow = 16'd97; req_op = 2'd1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("rc_busy_%0d", k), busy, 1);
      chk($sformatf("rc_valid_%0d", k), cvalid, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rc_ready_%0d", k), ready, 0);
      if (k % 2 == 0) begin
        chk($sformatf("rc_type_%0d", k), ctype, exp_t[k/2]);
        chk($sformatf("rc_data_%0d", k), cdata, exp_d[k/2]);
      end
      step();
    end
    chk("rc_busy_end", busy, 0);
    chk("rc_valid_end", cvalid, 0);
    chk("rc_ready_end", ready, 1);

    // Test 3: back-to-back instance
    exp_d = '{16'd0, 16'd10, 16'd20, 16'd4, 16'd0};
    req_op = 2'd3; req_green = 16'd10; req_red = 16'd20; req_yellow = 16'd4;
    req_valid0 = 1'b1;
    step();
    req_valid0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b2b_valid_%0d", k), cvalid0, 1);
      chk($sformatf("b2b_type_%0d", k), ctype0, exp_t[k]);
      chk($sformatf("b2b_data_%0d", k), cdata0, exp_d[k]);
      chk($sformatf("b2b_busy_%0d", k), busy0, 1);
      step();
    end
    chk("b2b_valid_end", cvalid0, 0);
    chk("b2b_ready_end", ready0, 1);
    chk("b2b_busy_end", busy0, 0);

    // Test 4: rejected RECONFIG (yellow below minimum)
    send(2'd3, 16'd5, 16'd7, 16'd0);
    chk("rej_err", err, 1);
    chk("rej_valid", cvalid, 0);
    chk("rej_ready", ready, 1);
    chk("rej_busy", busy, 0);
    step();
    chk("rej_err_end", err, 0);
    chk("rej_valid_end", cvalid, 0);
    // Minimum time itself is legal
    send(2'd3, 16'd1, 16'd1, 16'd1);
    chk("min_err", err, 0);
    chk("min_valid", cvalid, 1);
    for (int k = 0; k < 9; k++) step();
    chk("min_ready_end", ready, 1);

    // Test 5: OFF held during a RECONFIG
    t5 = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    send(2'd3, 16'd5, 16'd7, 16'd3);
    req_op = 2'd1; req_valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      logic exp_v;
      exp_v = ((k % 2 == 0) && (k <= 8)) || (k == 10);
      chk($sformatf("hold_valid_%0d", k), cvalid, exp_v);
      if (exp_v) chk($sformatf("hold_type_%0d", k), ctype, t5[(k == 10) ? 5 : k/2]);
      chk($sformatf("hold_ready_%0d", k), ready, (k == 9) ? 1 : 0);
      step();
      if (k == 9) req_valid = 1'b0;
    end
    chk("hold_valid_end", cvalid, 0);
    chk("hold_ready_end", ready, 1);

    // Test 6: reset in the middle of a RECONFIG
    send(2'd3, 16'd5, 16'd7, 16'd3);
    step(); step();
    chk("ab_second_cmd", ctype, 3);
    chk("ab_second_valid", cvalid, 1);
    srst = 1'b1;
    step();
    chk("ab_valid", cvalid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_type", ctype, 0);
    chk("ab_data", cdata, 0);
    chk("ab_ready", ready, 0);
    srst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("ab_quiet_%0d", k), cvalid, 0);
    end
    chk("ab_ready_back", ready, 1);
    send(2'd0, 16'd0, 16'd0, 16'd0);
    chk("ab_on_valid", cvalid, 1);
    chk("ab_on_type", ctype, 0);
    step();
    chk("ab_on_end", cvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
